ptp_tfp: RTL
============

// Module: ptp_tfp
// PURPOSE
//  PTP transmit frame parser. Sits on the MAC transmit client path, before the TX timestamp capture and one-step logic.
//  Walks each outgoing frame byte-by-byte: L2 (up to two VLAN/QinQ tags), IPv4/UDP, IPv6/UDP.
//  Recognises PTP messages (Ethertype 88F7, or UDP dst port 319/320).
//  Reports messageType, sequenceId, sourcePortIdentity, event flag and the PTP header byte offset.
// PARAMETERS
//  MAX_TAGS   2    max stacked 8100/88A8 tags accepted; a further tag means non-PTP
//  OFS_W      11   width of byte counter / offset outputs (saturating)
// PORTS
//  clk              in   1   system clock (single clock domain)
//  rst_n            in   1   asynchronous active-low reset
//  tx_en            in   1   frame envelope; first qualified byte while high is DA[0]
//  tx_dv            in   1   byte qualifier; state and counters advance only when tx_en & tx_dv
//  txd              in   8   transmit byte
//  ptp_valid        out  1   one-cycle pulse: complete PTP header fields captured
//  ptp_event        out  1   messageType < 4 (Sync, Delay_Req, Pdelay_Req, Pdelay_Resp)
//  ptp_udp          out  1   message was carried in UDP (0 = L2 88F7)
//  ptp_msg_type     out  4   PTP byte0[3:0]
//  ptp_seq_id       out  16  PTP bytes 30-31, big-endian
//  ptp_src_port_id  out  80  PTP bytes 20-29, byte20 in [79:72]
//  ptp_hdr_ofs      out  OFS_W  frame byte index of PTP byte0 (DA[0]=0)
//  ptp_abort        out  1   one-cycle pulse: tx_en fell while in PTP state before byte 31
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; byte counter 0; tag count 0.
//  Byte counter bcnt counts qualified bytes from DA[0]; it saturates at 2^OFS_W-1 with no wrap.
//  FSM states, advancing on qualified bytes only:
//   IDLE  -> MAC on the first qualified byte with tx_en=1. Entry to MAC requires tx_en low for >=1 cycle since the last frame.
//   MAC   bytes 0-11; -> ETYP.
//   ETYP  2-byte type:
//         8100/88A8 and tags<MAX_TAGS -> TAG (skip 2 TCI bytes), then ETYP again.
//         88F7 -> PTP.
//         0800 -> IP4.
//         86DD -> IP6.
//         Any other value, or a tag beyond MAX_TAGS -> SKIP.
//   IP4   byte0 must be 0x45..0x4F, else SKIP. Store IHL. Byte9 must be 0x11, else SKIP.
//         -> UDP at IP byte IHL*4.
//   IP6   byte0[7:4] must be 6. Byte6 (next header) must be 0x11, else SKIP.
//         -> UDP at IP byte 40. Extension headers are not parsed.
//   UDP   bytes 2-3 (dst port) must be 0x013F or 0x0140, else SKIP.
//         -> PTP after UDP byte 7.
//   PTP   latch ptp_hdr_ofs=bcnt at byte0. Capture msgType (byte0), srcPortId (20-29), seqId (30-31).
//         -> SKIP after byte 31.
//   SKIP  wait for tx_en=0 -> IDLE.
//  Outputs:
//   ptp_valid pulses in the clock after byte31 is accepted.
//   msg_type, seq_id, src_port_id, event, udp and hdr_ofs update together on that edge.
//   They hold until the next ptp_valid.
//   Partial captures never drive the outputs; they go to shadow registers first.
//  tx_en low in any state -> IDLE next cycle.
//   ptp_abort pulses only if the state was PTP.
//   No ptp_valid; the held outputs are unchanged.
//  tx_dv low with tx_en high: full hold, with no state, counter or capture change.
//  Frame shorter than a header field simply aborts as above. Runt frames never yield ptp_valid.
//  Async reset mid-frame: immediate return to reset values.
//   The remainder of that frame is ignored until tx_en has been low for 1 cycle.
// TESTING
//  1. L2 Sync:
//     frame DA/SA, 88F7, PTP byte0=0x10, srcPort=00:11:..:99, seq=0x1234
//     -> ptp_valid 1 clk after byte 45 (frame index 45)
//     -> msg_type=0, event=1, udp=0, hdr_ofs=14, seq_id=0x1234.
//  2. QinQ+VLAN IPv4/UDP:
//     88A8, 8100, 0800, IHL=6, proto 0x11, dport 320, Follow_Up (type 8)
//     -> hdr_ofs=14+8+24+8=54, event=0, udp=1.
//  3. IPv6/UDP dport 319, Delay_Req
//     -> hdr_ofs=62, msg_type=1. The same frame with next header 0x06 produces no ptp_valid.
//  4. tx_en dropped at PTP byte 25
//     -> ptp_abort pulse, no ptp_valid, outputs keep the previous message values.
//     A following good frame is reported normally.
//  5. Third VLAN tag before 88F7 -> no ptp_valid.
//     tx_dv toggled 50% during case 1 -> identical outputs.
//     rst_n asserted mid-PTP -> all outputs 0 immediately.

Source files
------------

// File: rtl/ptp_tfp.sv
// PTP transmit frame parser: walks each outgoing frame (L2 with up to MAX_TAGS tags, IPv4/UDP, IPv6/UDP)
// and reports the messageType, sequenceId, sourcePortIdentity and header offset of any PTP message found.
module ptp_tfp #(
   parameter int MAX_TAGS = 2,
   parameter int OFS_W    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_en,
   input  logic             tx_dv,
   input  logic [7:0]       txd,
   output logic             ptp_valid,
   output logic             ptp_event,
   output logic             ptp_udp,
   output logic [3:0]       ptp_msg_type,
   output logic [15:0]      ptp_seq_id,
   output logic [79:0]      ptp_src_port_id,
   output logic [OFS_W-1:0] ptp_hdr_ofs,
   output logic             ptp_abort
);

   localparam int TAG_W = $clog2(MAX_TAGS + 2);
   localparam logic [TAG_W-1:0] MAX_TAGS_C = TAG_W'(MAX_TAGS);

   typedef enum logic [3:0] {
      S_IDLE, S_MAC, S_ETYP, S_TAG, S_IP4, S_IP6, S_UDP, S_PTP, S_SKIP
   } state_t;

   state_t           state_q, state_d;
   logic             armed_q, armed_d;
   logic [OFS_W-1:0] bcnt_q, bcnt_d;
   logic [5:0]       fcnt_q, fcnt_d;
   logic [TAG_W-1:0] tags_q, tags_d;
   logic [7:0]       etyp_hi_q, etyp_hi_d;
   logic [3:0]       ihl_q, ihl_d;

   // Shadow copies of a PTP header in progress; only published when byte 31 arrives.
   logic             sh_udp_q, sh_udp_d;
   logic [3:0]       sh_type_q, sh_type_d;
   logic [OFS_W-1:0] sh_ofs_q, sh_ofs_d;
   logic [79:0]      sh_src_q, sh_src_d;
   logic [7:0]       sh_seq_hi_q, sh_seq_hi_d;

   logic             valid_q, valid_d;
   logic             abort_q, abort_d;
   logic             event_q, event_d;
   logic             udp_q, udp_d;
   logic [3:0]       type_q, type_d;
   logic [15:0]      seq_q, seq_d;
   logic [79:0]      src_q, src_d;
   logic [OFS_W-1:0] ofs_q, ofs_d;

   logic [OFS_W-1:0] cur_idx;
   logic [OFS_W-1:0] bcnt_inc;
   logic [5:0]       fcnt_inc;
   logic [15:0]      etype;
   logic [5:0]       ip4_last;

   assign cur_idx  = (state_q == S_IDLE) ? '0 : bcnt_q;
   assign bcnt_inc = (cur_idx == {OFS_W{1'b1}}) ? cur_idx : cur_idx + 1'b1;
   assign fcnt_inc = fcnt_q + 6'd1;
   assign etype    = {etyp_hi_q, txd};
   assign ip4_last = {ihl_q, 2'b00} - 6'd1;

   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      bcnt_d      = bcnt_q;
      fcnt_d      = fcnt_q;
      tags_d      = tags_q;
      etyp_hi_d   = etyp_hi_q;
      ihl_d       = ihl_q;
      sh_udp_d    = sh_udp_q;
      sh_type_d   = sh_type_q;
      sh_ofs_d    = sh_ofs_q;
      sh_src_d    = sh_src_q;
      sh_seq_hi_d = sh_seq_hi_q;
      valid_d     = 1'b0;
      abort_d     = 1'b0;
      event_d     = event_q;
      udp_d       = udp_q;
      type_d      = type_q;
      seq_d       = seq_q;
      src_d       = src_q;
      ofs_d       = ofs_q;

      if (!tx_en) begin
         armed_d = 1'b1;
         abort_d = (state_q == S_PTP);
         state_d = S_IDLE;
         bcnt_d  = '0;
         fcnt_d  = '0;
         tags_d  = '0;
      end else if (tx_dv) begin
         if (state_q != S_IDLE) begin
            bcnt_d = bcnt_inc;
         end
         unique case (state_q)
            S_IDLE: begin
               // A frame already in flight when we were (re)armed is ignored to its end.
               if (armed_q) begin
                  armed_d = 1'b0;
                  state_d = S_MAC;
                  bcnt_d  = bcnt_inc;
                  fcnt_d  = 6'd1;
                  tags_d  = '0;
               end
            end
            S_MAC: begin
               if (fcnt_q == 6'd11) begin
                  state_d = S_ETYP;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_inc;
               end
            end
            S_ETYP: begin
               if (fcnt_q == 6'd0) begin
                  etyp_hi_d = txd;
                  fcnt_d    = 6'd1;
               end else begin
                  fcnt_d = '0;
                  if (etype == 16'h8100 || etype == 16'h88A8) begin
                     if (tags_q < MAX_TAGS_C) begin
                        state_d = S_TAG;
                        tags_d  = tags_q + 1'b1;
                     end else begin
                        state_d = S_SKIP;
                     end
                  end else if (etype == 16'h88F7) begin
                     state_d  = S_PTP;
                     sh_udp_d = 1'b0;
                  end else if (etype == 16'h0800) begin
                     state_d = S_IP4;
                  end else if (etype == 16'h86DD) begin
                     state_d = S_IP6;
                  end else begin
                     state_d = S_SKIP;
                  end
               end
            end
            S_TAG: begin
               if (fcnt_q == 6'd1) begin
                  state_d = S_ETYP;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = 6'd1;
               end
            end
            S_IP4: begin
               fcnt_d = fcnt_inc;
               if (fcnt_q == 6'd0) begin
                  if (txd >= 8'h45 && txd <= 8'h4F) ihl_d = txd[3:0];
                  else                              state_d = S_SKIP;
               end else if (fcnt_q == 6'd9 && txd != 8'h11) begin
                  state_d = S_SKIP;
               end else if (fcnt_q == ip4_last) begin
                  state_d = S_UDP;
                  fcnt_d  = '0;
               end
            end
            S_IP6: begin
               fcnt_d = fcnt_inc;
               if (fcnt_q == 6'd0 && txd[7:4] != 4'h6) begin
                  state_d = S_SKIP;
               end else if (fcnt_q == 6'd6 && txd != 8'h11) begin
                  state_d = S_SKIP;
               end else if (fcnt_q == 6'd39) begin
                  state_d = S_UDP;
                  fcnt_d  = '0;
               end
            end
            S_UDP: begin
               fcnt_d = fcnt_inc;
               if (fcnt_q == 6'd2 && txd != 8'h01) begin
                  state_d = S_SKIP;
               end else if (fcnt_q == 6'd3 && txd != 8'h3F && txd != 8'h40) begin
                  state_d = S_SKIP;
               end else if (fcnt_q == 6'd7) begin
                  state_d  = S_PTP;
                  fcnt_d   = '0;
                  sh_udp_d = 1'b1;
               end
            end
            S_PTP: begin
               fcnt_d = fcnt_inc;
               if (fcnt_q == 6'd0) begin
                  sh_ofs_d  = cur_idx;
                  sh_type_d = txd[3:0];
               end else if (fcnt_q >= 6'd20 && fcnt_q <= 6'd29) begin
                  sh_src_d = {sh_src_q[71:0], txd};
               end else if (fcnt_q == 6'd30) begin
                  sh_seq_hi_d = txd;
               end else if (fcnt_q == 6'd31) begin
                  state_d = S_SKIP;
                  valid_d = 1'b1;
                  type_d  = sh_type_q;
                  event_d = (sh_type_q < 4'd4);
                  udp_d   = sh_udp_q;
                  seq_d   = {sh_seq_hi_q, txd};
                  src_d   = sh_src_q;
                  ofs_d   = sh_ofs_q;
               end
            end
            S_SKIP: begin
               state_d = S_SKIP;
            end
            default: begin
               state_d = S_SKIP;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b0;
         bcnt_q      <= '0;
         fcnt_q      <= '0;
         tags_q      <= '0;
         etyp_hi_q   <= '0;
         ihl_q       <= '0;
         sh_udp_q    <= 1'b0;
         sh_type_q   <= '0;
         sh_ofs_q    <= '0;
         sh_src_q    <= '0;
         sh_seq_hi_q <= '0;
         valid_q     <= 1'b0;
         abort_q     <= 1'b0;
         event_q     <= 1'b0;
         udp_q       <= 1'b0;
         type_q      <= '0;
         seq_q       <= '0;
         src_q       <= '0;
         ofs_q       <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         bcnt_q      <= bcnt_d;
         fcnt_q      <= fcnt_d;
         tags_q      <= tags_d;
         etyp_hi_q   <= etyp_hi_d;
         ihl_q       <= ihl_d;
         sh_udp_q    <= sh_udp_d;
         sh_type_q   <= sh_type_d;
         sh_ofs_q    <= sh_ofs_d;
         sh_src_q    <= sh_src_d;
         sh_seq_hi_q <= sh_seq_hi_d;
         valid_q     <= valid_d;
         abort_q     <= abort_d;
         event_q     <= event_d;
         udp_q       <= udp_d;
         type_q      <= type_d;
         seq_q       <= seq_d;
         src_q       <= src_d;
         ofs_q       <= ofs_d;
      end
   end

   assign ptp_valid       = valid_q;
   assign ptp_abort       = abort_q;
   assign ptp_event       = event_q;
   assign ptp_udp         = udp_q;
   assign ptp_msg_type    = type_q;
   assign ptp_seq_id      = seq_q;
   assign ptp_src_port_id = src_q;
   assign ptp_hdr_ofs     = ofs_q;

endmodule
